cba_adder_pipe: RTL and testbench

Parametrised, pipelined successor to the 32-bit carry bypass adder (CBAdder_32).
- Generalised in operand width, bypass-group size and pipeline depth; adds add/subtract mode and a valid/ready handshake with backpressure.
- Sits in the datapath library as the drop-in registered adder for ALU and accumulator paths that need higher clock rates than the combinational CBA allows.

---
 rtl/cba_adder_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_cba_adder_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cba_adder_pipe.sv
// cba_adder_pipe -- pipelined carry-bypass adder/subtractor with valid/ready.
//
// The WIDTH-bit carry chain is cut into STAGES equal segments of WIDTH/STAGES
// bits. Stage k adds segment k using the carry registered out of stage k-1.
// Operands not yet consumed ride along in per-stage registers (skew), and the
// partial sum collects finished low segments as the beat walks down the pipe.
// Inside a segment, BLOCK-bit groups ripple internally; a group whose bits all
// propagate passes its carry-in straight to its carry-out (the bypass mux).
//
// Optional feature macro: CBA_PIPE_SATURATE_EN (adds the 'sat' input).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  input beat handshake
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored)
//   out_valid, out_ready result beat handshake
//   sum, cout           result and carry out of the MSB (sub: 1 = no borrow)
//   overflow, zero      signed overflow, sum == 0
//   sat                 (CBA_PIPE_SATURATE_EN only) clamp on signed overflow
//
// Handshake: a beat moves on a rising edge when valid & ready are both high
// on that side. advance = !out_valid | out_ready; in_ready = advance. When
// advance is low the whole pipe freezes (bubbles are kept, not collapsed),
// so the outputs stay stable while out_valid & !out_ready.
module cba_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
`ifdef CBA_PIPE_SATURATE_EN
  ,
  input  logic             sat
`endif
);

  localparam int SEG    = WIDTH / STAGES;
  localparam int GROUPS = SEG / BLOCK;

  logic              advance;
  logic [STAGES-1:0] v_q, v_n;
  logic [STAGES-1:0] c_q, c_n;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic              ovf_q, ovf_n;
  logic              zero_q, zero_n;
`ifdef CBA_PIPE_SATURATE_EN
  logic [STAGES-1:0] sat_q, sat_n;
`endif

  assign advance   = !v_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Next-state for every stage. After the stage loop the working variables
  // still hold the final stage's values, which the flag logic reuses.
  always_comb begin : stage_logic
    logic [WIDTH-1:0] op_a, op_b, part;
    logic             seg_c, grp_c, grp_p, msb_c;
    int               p, idx;
`ifdef CBA_PIPE_SATURATE_EN
    logic             sat_i;
    sat_i = 1'b0;
    sat_n = '0;
`endif
    op_a   = '0;
    op_b   = '0;
    part   = '0;
    seg_c  = 1'b0;
    grp_c  = 1'b0;
    grp_p  = 1'b0;
    msb_c  = 1'b0;
    p      = 0;
    idx    = 0;
    v_n    = '0;
    c_n    = '0;
    ovf_n  = 1'b0;
    zero_n = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      a_n[k] = '0;
      b_n[k] = '0;
      s_n[k] = '0;
    end

    for (int k = 0; k < STAGES; k++) begin
      // p is the upstream register index; clamped so stage 0 never reads
      // outside the arrays.
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        // Subtraction as a + ~b + 1; the external carry is unused then.
        op_a   = a;
        op_b   = sub ? ~b : b;
        seg_c  = sub | cin;
        part   = '0;
        v_n[k] = in_valid;
`ifdef CBA_PIPE_SATURATE_EN
        sat_i  = sat;
`endif
      end else begin
        op_a   = a_q[p];
        op_b   = b_q[p];
        seg_c  = c_q[p];
        part   = s_q[p];
        v_n[k] = v_q[p];
`ifdef CBA_PIPE_SATURATE_EN
        sat_i  = sat_q[p];
`endif
      end

      for (int g = 0; g < GROUPS; g++) begin
        grp_c = seg_c;
        grp_p = 1'b1;
        for (int j = 0; j < BLOCK; j++) begin
          idx = k * SEG + g * BLOCK + j;
          if (idx == WIDTH - 1) msb_c = grp_c;
          part[idx] = op_a[idx] ^ op_b[idx] ^ grp_c;
          grp_c     = (op_a[idx] & op_b[idx]) | (grp_c & (op_a[idx] ^ op_b[idx]));
          grp_p     = grp_p & (op_a[idx] ^ op_b[idx]);
        end
        // Bypass: an all-propagate group forwards its carry-in unchanged.
        seg_c = grp_p ? seg_c : grp_c;
      end

      a_n[k] = op_a;
      b_n[k] = op_b;
      s_n[k] = part;
      c_n[k] = seg_c;
`ifdef CBA_PIPE_SATURATE_EN
      sat_n[k] = sat_i;
`endif
    end

    // Final-stage flags.
    ovf_n = msb_c ^ seg_c;
`ifdef CBA_PIPE_SATURATE_EN
    // On signed overflow both addends share a sign, which is the sign of the
    // true result; clamp towards it.
    if (sat_i && ovf_n) begin
      part = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    s_n[STAGES-1] = part;
    zero_n        = (part == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`ifdef CBA_PIPE_SATURATE_EN
      sat_q  <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q <= v_n;
      // Data registers only load under a valid beat; bubbles leave them idle.
      for (int k = 0; k < STAGES; k++) begin
        if (v_n[k]) begin
          a_q[k] <= a_n[k];
          b_q[k] <= b_n[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
`ifdef CBA_PIPE_SATURATE_EN
          sat_q[k] <= sat_n[k];
`endif
        end
      end
      if (v_n[STAGES-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

endmodule

// File: tb/tb_cba_adder_pipe.sv
// Directed testbench for cba_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
// Expected results are hand-computed constants packed as {zero,ovf,cout,sum}.
module tb_cba_adder_pipe;
  localparam int W  = 32;
  localparam int ST = 2;
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;
`ifdef CBA_PIPE_SATURATE_EN
  logic         sat = 1'b0;
`endif

  int checks = 0;
  int passed = 0;
  logic [EW-1:0] exp_q[$];

  cba_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
`ifdef CBA_PIPE_SATURATE_EN
    , .sat(sat)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [W-1:0] s, input logic c,
                                       input logic o, input logic z);
    return {z, o, c, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Scoreboard: a result transfers on the edge following a negedge where
  // out_valid & out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        check("result", {29'd0, zero, overflow, cout, sum}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: offer one beat, wait for acceptance, optionally expect its result.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts, input bit keep, input logic [EW-1:0] e);
    int n = 0;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
    else if (keep) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 64'd0);
  endtask

  // Called right after the accept edge of a lone beat.
  task automatic lat_check(input string tag);
    for (int i = 1; i < ST; i++) begin
      @(negedge clk);
      check({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    check({tag, "_arrive"}, {63'd0, out_valid}, 64'd1);
  endtask

  logic [W-1:0]  sa [8];
  logic [W-1:0]  sb [8];
  logic [EW-1:0] se [8];

  initial begin
    int sent;
    // Reset
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_flags", {61'd0, cout, overflow, zero}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Test 1: 7FFFFFFF + 1, with latency
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
    lat_check("lat1");
    drain();

    // Test 2: overflow into positive, then full bypass chain
    send(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 1'b1, 1'b0, 1'b1));
    send(32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b1, mk(32'h00000004, 1'b0, 1'b0, 1'b0));
    drain();

    // Test 3: subtract (cin=1 must be ignored)
    send(32'h00000005, 32'h0000000A, 1'b1, 1'b1, 1'b1, mk(32'hFFFFFFFB, 1'b0, 1'b0, 1'b0));
    send(32'hFFFFFC19, 32'hFFFFFC19, 1'b0, 1'b1, 1'b1, mk(32'h00000000, 1'b1, 1'b0, 1'b1));
    drain();

    // Test 4: 8 back-to-back beats with a 3-cycle downstream stall
    sa[0] = 32'h000000A5; sb[0] = 32'h000003E8; se[0] = mk(32'h0000048D, 1'b0, 1'b0, 1'b0);
    sa[1] = 32'hFFFFFE0C; sb[1] = 32'h000007D0; se[1] = mk(32'h000005DC, 1'b1, 1'b0, 1'b0);
    sa[2] = 32'h12345678; sb[2] = 32'h11111111; se[2] = mk(32'h23456789, 1'b0, 1'b0, 1'b0);
    sa[3] = 32'hFFFFFFFF; sb[3] = 32'hFFFFFFFF; se[3] = mk(32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    sa[4] = 32'h40000000; sb[4] = 32'h40000000; se[4] = mk(32'h80000000, 1'b0, 1'b1, 1'b0);
    sa[5] = 32'h0000FFFF; sb[5] = 32'h00000001; se[5] = mk(32'h00010000, 1'b0, 1'b0, 1'b0);
    sa[6] = 32'h00000000; sb[6] = 32'h00000000; se[6] = mk(32'h00000000, 1'b0, 1'b0, 1'b1);
    sa[7] = 32'hDEADBEEF; sb[7] = 32'h21524111; se[7] = mk(32'h00000000, 1'b1, 1'b0, 1'b1);
    sent = 0;
    cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 8) begin
        in_valid = 1'b1; a = sa[sent]; b = sb[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        if (exp_q.size() != 0)
          check("stall_hold", {29'd0, zero, overflow, cout, sum}, {29'd0, exp_q[0]});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(se[sent]);
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", sent, 64'd8);
    check("stream_drained", exp_q.size(), 64'd0);

    // Test 5: async reset with two beats in flight
    send(32'h00000011, 32'h00000022, 1'b0, 1'b0, 1'b0, '0);
    send(32'h00000033, 32'h00000044, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_sum", {32'd0, sum}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(32'h00001000, 32'h00000234, 1'b0, 1'b0, 1'b1, mk(32'h00001234, 1'b0, 1'b0, 1'b0));
    lat_check("lat_after_rst");
    drain();

`ifdef CBA_PIPE_SATURATE_EN
    // Test 6: saturation
    sat = 1'b1;
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0));
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, mk(32'h80000000, 1'b1, 1'b1, 1'b0));
    sat = 1'b0;
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
